mult_div_unit: RTL and testbench

Parametrised multicycle integer multiply/divide unit with architectural Hi/Lo registers, for the multicycle CPU datapath. Implements MULT, MULTU, DIV, DIVU as iterative shift-add/restoring-divide, one bit per clock. The control unit starts an operation with a single-cycle strobe, stalls on `busy`, and reads Hi/Lo after `done`. Hi/Lo are also directly writable (mthi/mtlo) when idle.

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural Hi/Lo registers.
// One result bit per clock: shift-add multiply, restoring divide, sign fix-up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               dz_pend;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    signed_op;
  logic                    div_op;
  logic                    a_neg;
  logic                    b_neg;
  logic                    b_zero;
  logic [WIDTH-1:0]        a_mag;
  logic [WIDTH-1:0]        b_mag;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (-v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (-v) : v;
  endfunction

  // Operand decode: magnitudes of signed operands; most-negative maps onto itself,
  // which is the correct unsigned magnitude 2^(WIDTH-1).
  assign a_s       = A;
  assign b_s       = B;
  assign signed_op = ~op[0];
  assign div_op    = op[1];
  assign a_neg     = signed_op & a_s[WIDTH-1];
  assign b_neg     = signed_op & b_s[WIDTH-1];
  assign b_zero    = (B == '0);
  assign a_mag     = neg_if(A, a_neg);
  assign b_mag     = neg_if(B, b_neg);

  // Multiply step: acc = {partial product high, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: acc = {remainder, quotient/dividend}
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd});
  assign div_diff = div_sh[WIDTH-1:0] - opnd;
  assign div_nxt  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prod_fix = neg2_if(acc, neg_res);
  assign quot_fix = neg_if(acc[WIDTH-1:0], neg_res);
  assign rem_fix  = neg_if(acc[2*WIDTH-1:WIDTH], neg_rem);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !(div_op && b_zero)) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      dz_pend  <= 1'b0;
      cnt      <= '0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      done     <= dz_pend;
      div_zero <= dz_pend;
      dz_pend  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_wr) Hi <= wdata;
          if (lo_wr) Lo <= wdata;
          if (start) begin
            if (div_op && b_zero) begin
              dz_pend <= 1'b1;
            end else begin
              busy <= 1'b1;
              cnt  <= CW'(WIDTH);
            end
          end
        end
        CALC: cnt <= cnt - CW'(1);
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            Hi <= rem_fix;
            Lo <= quot_fix;
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      is_div  <= div_op;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (div_op) begin
        opnd <= b_mag;
        acc  <= {{WIDTH{1'b0}}, a_mag};
      end else begin
        opnd <= a_mag;
        acc  <= {{WIDTH{1'b0}}, b_mag};
      end
    end else if (state == CALC) begin
      acc <= is_div ? div_nxt : mul_nxt;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: WIDTH=32 and WIDTH=8 instances, queue scoreboard.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst32, start32, hiwr32, lowr32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;

  logic        rst8, start8, hiwr8, lowr8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(rst32), .start(start32), .op(op32), .A(a32), .B(b32),
    .hi_wr(hiwr32), .lo_wr(lowr32), .wdata(wd32), .busy(busy32), .done(done32),
    .div_zero(dz32), .Hi(hi32), .Lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst8), .start(start8), .op(op8), .A(a8), .B(b8),
    .hi_wr(hiwr8), .lo_wr(lowr8), .wdata(wd8), .busy(busy8), .done(done8),
    .div_zero(dz8), .Hi(hi8), .Lo(lo8)
  );

  exp_t sb32[$];
  exp_t sb8[$];
  int   total  = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    return e;
  endfunction

  function automatic exp_t model32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      2'd0:    p = 64'(sa * sb_);
      2'd1:    p = {32'd0, a} * {32'd0, b};
      2'd2:    p = {32'(sa % sb_), 32'(sa / sb_)};
      default: p = {a % b, a / b};
    endcase
    return mk(p[63:32], p[31:0], 1'b0);
  endfunction

  // Waits for done after the start edge, then checks latency, busy length and result.
  task automatic finish32(input string tag);
    int   n, bc;
    exp_t g;
    n  = 0;
    bc = 0;
    while (!done32 && n < 200) begin
      if (busy32) bc++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busycyc"}, 64'(bc), 64'd33);
    g = sb32.pop_front();
    chk({tag, "_hi"}, {32'd0, hi32}, {32'd0, g.hi});
    chk({tag, "_lo"}, {32'd0, lo32}, {32'd0, g.lo});
    chk({tag, "_dz"}, {63'd0, dz32}, {63'd0, g.dz});
  endtask

  task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    sb32.push_back(e);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    tick();
    start32 = 1'b0;
    finish32(tag);
  endtask

  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input exp_t e);
    int   n, bc;
    exp_t g;
    sb8.push_back(e);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    tick();
    start8 = 1'b0;
    n  = 0;
    bc = 0;
    while (!done8 && n < 100) begin
      if (busy8) bc++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd9);
    chk({tag, "_busycyc"}, 64'(bc), 64'd9);
    g = sb8.pop_front();
    chk({tag, "_hi"}, {56'd0, hi8}, {32'd0, g.hi});
    chk({tag, "_lo"}, {56'd0, lo8}, {32'd0, g.lo});
    chk({tag, "_dz"}, {63'd0, dz8}, {63'd0, g.dz});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          n, dcnt;
    exp_t        g;

    rst32 = 1'b0; start32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0;
    hiwr32 = 1'b0; lowr32 = 1'b0; wd32 = '0;
    rst8 = 1'b0; start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0;
    hiwr8 = 1'b0; lowr8 = 1'b0; wd8 = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst_done", {63'd0, done32}, 64'd0);
    chk("rst_dz", {63'd0, dz32}, 64'd0);
    chk("rst_hi", {32'd0, hi32}, 64'd0);
    chk("rst_lo", {32'd0, lo32}, 64'd0);
    chk("rst8_hilo", {48'd0, hi8, lo8}, 64'd0);
    chk("rst8_busy", {63'd0, busy8}, 64'd0);
    rst32 = 1'b1;
    rst8  = 1'b1;
    tick();

    // Directed arithmetic
    run32("mult_7x-3", 2'd0, 32'd7, 32'hFFFF_FFFD, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
    tick();
    chk("done_falls", {63'd0, done32}, 64'd0);
    run32("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
    run32("divu_100_7", 2'd3, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
    run32("div_-7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    run32("div_min_-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0));
    tick();

    // Preload, then divide by zero
    hiwr32 = 1'b1; wd32 = 32'hAAAA_5555;
    tick();
    hiwr32 = 1'b0;
    chk("mthi", {32'd0, hi32}, {32'd0, 32'hAAAA_5555});
    lowr32 = 1'b1; wd32 = 32'h1234_5678;
    tick();
    lowr32 = 1'b0;
    chk("mtlo", {32'd0, lo32}, {32'd0, 32'h1234_5678});
    sb32.push_back(mk(32'hAAAA_5555, 32'h1234_5678, 1'b1));
    start32 = 1'b1; op32 = 2'd3; a32 = 32'd55; b32 = 32'd0;
    tick();
    start32 = 1'b0;
    chk("dz_busy_k", {63'd0, busy32}, 64'd0);
    chk("dz_done_k", {63'd0, done32}, 64'd0);
    tick();
    g = sb32.pop_front();
    chk("dz_done", {63'd0, done32}, 64'd1);
    chk("dz_flag", {63'd0, dz32}, {63'd0, g.dz});
    chk("dz_busy", {63'd0, busy32}, 64'd0);
    chk("dz_hi", {32'd0, hi32}, {32'd0, g.hi});
    chk("dz_lo", {32'd0, lo32}, {32'd0, g.lo});
    tick();
    chk("dz_falls", {62'd0, done32, dz32}, 64'd0);

    // Write and start in the same idle cycle
    sb32.push_back(mk(32'd3, 32'd0, 1'b0));
    hiwr32 = 1'b1; wd32 = 32'h5A5A_5A5A;
    start32 = 1'b1; op32 = 2'd1; a32 = 32'h0001_0000; b32 = 32'h0003_0000;
    tick();
    start32 = 1'b0; hiwr32 = 1'b0;
    chk("wr_with_start", {32'd0, hi32}, {32'd0, 32'h5A5A_5A5A});
    finish32("multu_after_wr");
    tick();

    // Ignored start/hi_wr while busy, then reset mid-operation
    start32 = 1'b1; op32 = 2'd0; a32 = 32'd5; b32 = 32'd6;
    tick();
    start32 = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    start32 = 1'b1; hiwr32 = 1'b1; wd32 = 32'hDEAD_BEEF; op32 = 2'd1;
    tick();
    start32 = 1'b0; hiwr32 = 1'b0;
    chk("busy_hiwr_ign", {32'd0, hi32}, 64'd3);
    chk("busy_mid", {63'd0, busy32}, 64'd1);
    for (int i = 6; i < 10; i++) tick();
    rst32 = 1'b0;
    tick();
    rst32 = 1'b1;
    chk("abort_busy", {63'd0, busy32}, 64'd0);
    chk("abort_hilo", {hi32, lo32}, 64'd0);
    dcnt = 0;
    for (n = 0; n < 40; n++) begin
      if (done32) dcnt++;
      tick();
    end
    chk("abort_nodone", 64'(dcnt), 64'd0);

    // Randomised operations against the behavioural model
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i == 0) rb = 32'h0000_0001 << $urandom_range(0, 31);
      if (rop[1] && rb == '0) rb = 32'd1;
      run32("rnd", rop, ra, rb, model32(rop, ra, rb));
    end

    // Narrow instance, back-to-back start in the done cycle
    run8("w8_mult", 2'd0, 8'h80, 8'h80, mk(32'h40, 32'h00, 1'b0));
    run8("w8_divu_b2b", 2'd3, 8'd200, 8'd3, mk(32'd2, 32'd66, 1'b0));
    tick();
    chk("w8_done_falls", {63'd0, done8}, 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
